mux_4_1_arbiter: RTL and testbench
==================================

# mux_4_1_arbiter

Round-robin arbiter and sequencer for the 4:1 select datapath. Four requesters present data words on inputs A–D. The block grants one requester at a time and drives the mux select `S` from its registered grant. It forwards the selected word downstream over a valid/ready handshake and supports multi-beat bursts capped at `MAX_BURST`. It sits between the requester-side sources and the single shared downstream consumer.

## Interface
- `DATA_W`, default 8: width of each data path.
- `MAX_BURST`, default 4: maximum beats per grant; legal range 1–16.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  per-requester request; bit 0 = A … bit 3 = D.
- `last`  in  4  per-requester last-beat-of-burst flag, sampled on accepted beats.
- `data_a`, `data_b`, `data_c`, `data_d`  in  DATA_W  requester data.
- `gnt`  out  4  registered one-hot grant; all zero when idle.
- `sel`  out  2  registered mux select; 0 = A, 1 = B, 2 = C, 3 = D.
- `out_data`  out  DATA_W  mux output of `data_*` per `sel`.
- `out_valid`  out  1  downstream valid.
- `out_ready`  in  1  downstream ready.
- `accept`  out  4  combinational per-requester beat-taken strobe.

## Operation
- Reset (async assert, sync release) forces: state IDLE, `gnt`=0, `sel`=0, priority pointer `ptr`=0, `beat_cnt`=0.
  - Resulting outputs: `out_valid`=0, `accept`=0, `out_data`=`data_a`.
- State machine has two states, IDLE and BUSY.
- IDLE
  - If any `req` bit is set, the winner is the first set bit searching upward from `ptr`, mod 4.
  - Next edge: `gnt`=onehot(winner), `sel`=winner, `beat_cnt`=0, state goes to BUSY.
  - If no `req` bit is set, stay in IDLE.
- BUSY
  - `out_valid` = `req[sel]`.
  - `accept[i]` = `gnt[i]` & `out_valid` & `out_ready`.
  - A beat is accepted when `out_valid` & `out_ready`.
- Release occurs on either of these:
  - an accepted beat with `last[sel]`=1 or `beat_cnt`=`MAX_BURST`-1 (burst end);
  - `req[sel]`=0 (abandon; no beat taken).
- On release:
  - `ptr` = `sel`+1 mod 4.
  - The winner is re-arbitrated from the current `req` using the new `ptr`.
  - If a winner exists, new `gnt`/`sel` load on the same edge and state stays BUSY (no bubble). Otherwise go to IDLE with `gnt`=0.
  - The released requester may win again only if no other request is set.
- Accepted beat without release: `beat_cnt`++.
- `beat_cnt` width is clog2(`MAX_BURST`), minimum 1 bit; it never wraps past `MAX_BURST`-1.
- Under backpressure (`out_ready`=0), `gnt`, `sel` and `beat_cnt` hold. `out_data` tracks the live `data_*` of the granted requester, which must hold its word stable.

## Timing
- Request-to-grant latency: 1 cycle from a `req` sampled in IDLE.
- `out_valid` rises in the first cycle `gnt` is nonzero.
- Back-to-back bursts: the new grant is visible in the cycle after the releasing edge. Throughput is 1 beat/cycle with zero idle cycles.
- `out_valid` and `accept` depend combinationally on `req` and `out_ready`. `gnt` and `sel` are pure flops.
- `MAX_BURST`=1 gives one beat per grant; `last` is ignored.
- `rst_n` asserted mid-burst: `gnt`, `out_valid` and `accept` go to 0 immediately without waiting for `clk`. The partial burst is dropped and `ptr` returns to 0.

## Structure
- Shared package `mux_arb_pkg` holds:
  - state encoding: IDLE=1'b0, BUSY=1'b1;
  - `NUM_REQ`=4;
  - select constants `SEL_A` … `SEL_D`.
- Sub-module `rr_pick4`: combinational rotate-priority picker; inputs `req[3:0]`, `ptr[1:0]`; outputs `found`, `idx[1:0]`. It is used for both IDLE arbitration and release re-arbitration.
- The datapath is `DATA_W` instances of the existing `mux_4_1`, generated per bit. `S` is driven by `sel`.

## Test plan
- Reset: hold `rst_n`=0 with `req`=4'b1111. Required: `gnt`=0, `out_valid`=0, `out_data`=`data_a`. Then assert `rst_n`=0 mid-burst; `gnt` must clear before the next `clk` edge.
- Single beat: `req`=0001, `last`=0001, `data_a`=8'hA5, `out_ready`=1. Required: `gnt`=0001 one cycle later, `out_data`=A5, `accept`=0001 for 1 cycle, then IDLE with `gnt`=0.
- Round robin: `req`=1111, `last`=1111, `out_ready`=1 for 6 cycles. Required: `sel` sequence 0,1,2,3,0,1 with `out_valid` high every cycle.
- Backpressure: `req`=0100, `data_c`=8'h3C, `out_ready`=0 for 3 cycles, then 1. Required: `gnt`=0100, `sel`=2 and `out_valid`=1 stable throughout; `accept[2]` pulses only in the ready cycle.
- Burst cap, `MAX_BURST`=4: `req`=0110, `last`=0, `out_ready`=1. Required: 4 beats to requester 1, then 4 beats to requester 2, then requester 1 again, with no bubbles.
- Abandon: grant requester 3, then drop `req[3]` with `out_ready`=0 while `req[0]`=1. Required: no `accept`; `gnt`=0001 on the next edge; `ptr` wraps to 0.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the 4:1 round-robin arbiter and its picker.
package mux_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int NUM_REQ = 4;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_4_1.sv
// Single-bit 4:1 multiplexer; S selects A (0) through D (3).
module mux_4_1 (
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  input  logic [1:0] S,
  output logic       Y
);

  // Plain select decode.
  always_comb begin
    Y = A;
    case (S)
      2'd0: Y = A;
      2'd1: Y = B;
      2'd2: Y = C;
      2'd3: Y = D;
      default: Y = A;
    endcase
  end

endmodule

// File: rtl/rr_pick4.sv
// Rotating-priority picker: first set request bit at or above ptr, wrapping mod 4.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       found,
  output logic [1:0] idx
);

  // Scan four candidates starting at ptr; the first hit wins.
  always_comb begin
    logic [1:0] cand;
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_arbiter.sv
// Round-robin arbiter driving a DATA_W-wide 4:1 mux with valid/ready output
// and bursts of up to MAX_BURST beats per grant.
module mux_4_1_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic [DATA_W-1:0]  data_a,
  input  logic [DATA_W-1:0]  data_b,
  input  logic [DATA_W-1:0]  data_c,
  input  logic [DATA_W-1:0]  data_d,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         sel,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_REQ-1:0] accept
);

  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic       beat;
  logic       release_grant;
  logic [1:0] pick_ptr;
  logic       pick_found;
  logic [1:0] pick_idx;

  // While busy the picker searches from just past the current owner, so the
  // same single picker serves both idle arbitration and release re-arbitration.
  assign pick_ptr = (state_q == BUSY) ? sel_q + 2'd1 : ptr_q;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (pick_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Handshake strobes and release decision for the current owner.
  always_comb begin
    out_valid     = (state_q == BUSY) && req[sel_q];
    beat          = out_valid && out_ready;
    accept        = beat ? gnt_q : '0;
    release_grant = (state_q == BUSY) &&
                    (!req[sel_q] || (beat && (last[sel_q] || beat_cnt_q == CNT_MAX)));
  end

  // Next-state logic: grant from idle, hand over without a bubble on release.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BUSY;
          gnt_d      = onehot4(pick_idx);
          sel_d      = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BUSY: begin
        if (release_grant) begin
          ptr_d      = sel_q + 2'd1;
          beat_cnt_d = '0;
          if (pick_found) begin
            gnt_d = onehot4(pick_idx);
            sel_d = pick_idx;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any partial burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= SEL_A;
      ptr_q      <= 2'd0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign gnt = gnt_q;
  assign sel = sel_q;

  // Bit-sliced datapath built from the shared 1-bit mux cell.
  for (genvar b = 0; b < DATA_W; b++) begin : g_mux
    mux_4_1 u_mux (
      .A (data_a[b]),
      .B (data_b[b]),
      .C (data_c[b]),
      .D (data_d[b]),
      .S (sel_q),
      .Y (out_data[b])
    );
  end

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Scoreboard bench for mux_4_1_arbiter: a driver runs a behavioural model and
// queues expectations, a negedge monitor pops and compares.
module tb_mux_4_1_arbiter;

  localparam int DW   = 8;
  localparam int MAXB = 4;

  logic          clk;
  logic          rst_n;
  logic [3:0]    req, last;
  logic [DW-1:0] data_a, data_b, data_c, data_d;
  logic [3:0]    gnt;
  logic [1:0]    sel;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    accept;

  int checks = 0;
  int passes = 0;
  logic mon_en = 1'b0;

  typedef struct {
    logic [3:0]    gnt;
    logic          valid;
    logic [3:0]    acc;
    logic [1:0]    sel;
    logic [DW-1:0] data;
  } stat_t;

  typedef struct {
    logic [1:0]    who;
    logic [DW-1:0] data;
  } beat_t;

  stat_t stat_q[$];
  beat_t beat_q[$];

  // Reference model state: current owner (-1 = none), search start, beats taken.
  int owner = -1;
  int mptr  = 0;
  int mbeats = 0;

  mux_4_1_arbiter #(.DATA_W(DW), .MAX_BURST(MAXB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .gnt       (gnt),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .accept    (accept)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic int firstFrom(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Drive one cycle of inputs just after the rising edge, predict this cycle's
  // outputs, then advance the model to the state after the next rising edge.
  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l, input logic rdy,
                               input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [DW-1:0] c, input logic [DW-1:0] d);
    stat_t e;
    beat_t bt;
    logic [DW-1:0] dv [4];
    logic took;
    @(posedge clk);
    #1;
    req = r; last = l; out_ready = rdy;
    data_a = a; data_b = b; data_c = c; data_d = d;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    e.gnt   = (owner < 0) ? 4'b0000 : (4'b0001 << owner);
    e.valid = (owner >= 0) && r[owner];
    e.sel   = (owner < 0) ? 2'd0 : 2'(owner);
    e.data  = (owner < 0) ? a : dv[owner];
    took    = e.valid && rdy;
    e.acc   = took ? e.gnt : 4'b0000;
    stat_q.push_back(e);
    if (took) begin
      bt.who  = 2'(owner);
      bt.data = dv[owner];
      beat_q.push_back(bt);
    end
    if (owner < 0) begin
      owner  = firstFrom(r, mptr);
      mbeats = 0;
    end else if (!r[owner] || (took && (l[owner] || mbeats + 1 == MAXB))) begin
      mptr   = (owner + 1) % 4;
      owner  = firstFrom(r, mptr);
      mbeats = 0;
    end else if (took) begin
      mbeats++;
    end
  endtask

  // Monitor: compare per-cycle status and every accepted beat.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (stat_q.size() > 0) begin
        stat_t e;
        e = stat_q.pop_front();
        checkOutput("gnt", 32'(gnt), 32'(e.gnt));
        checkOutput("out_valid", 32'(out_valid), 32'(e.valid));
        checkOutput("accept", 32'(accept), 32'(e.acc));
        if (e.gnt != 4'b0000) checkOutput("sel", 32'(sel), 32'(e.sel));
        if (e.valid) checkOutput("out_data", 32'(out_data), 32'(e.data));
      end
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          checkOutput("beat_unexpected", 32'(1), 32'(0));
        end else begin
          beat_t bt;
          bt = beat_q.pop_front();
          checkOutput("beat_sel", 32'(sel), 32'(bt.who));
          checkOutput("beat_data", 32'(out_data), 32'(bt.data));
        end
      end
    end
  end

  initial begin
    logic [3:0] r, l;
    rst_n = 1'b0;
    req = 4'b1111; last = 4'b0000; out_ready = 1'b1;
    data_a = 8'h11; data_b = 8'h22; data_c = 8'h33; data_d = 8'h44;
    #12;
    checkOutput("reset_gnt", 32'(gnt), 32'h0);
    checkOutput("reset_valid", 32'(out_valid), 32'h0);
    checkOutput("reset_accept", 32'(accept), 32'h0);
    checkOutput("reset_sel", 32'(sel), 32'h0);
    checkOutput("reset_data", 32'(out_data), 32'h11);
    req = 4'b0000;
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single beat from A.
    applyStimulus(4'b0001, 4'b0001, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);
    applyStimulus(4'b0000, 4'b0000, 1'b1, 8'hA5, 8'h00, 8'h00, 8'h00);

    // Get into a burst on B, then reset asynchronously mid-burst.
    for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 4'b0000, 1'b1, 8'h01, 8'h5B, 8'h03, 8'h04);
    @(posedge clk);
    #1 mon_en = 1'b0;
    checkOutput("pre_reset_gnt", 32'(gnt), 32'h2);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_gnt", 32'(gnt), 32'h0);
    checkOutput("async_reset_valid", 32'(out_valid), 32'h0);
    checkOutput("async_reset_accept", 32'(accept), 32'h0);
    owner = -1; mptr = 0; mbeats = 0;
    @(negedge clk);
    req = 4'b0000;
    #2 rst_n = 1'b1;
    mon_en = 1'b1;

    // Round robin over all four with single-beat bursts.
    for (int i = 0; i < 7; i++) applyStimulus(4'b1111, 4'b1111, 1'b1, 8'hA0, 8'hB1, 8'hC2, 8'hD3);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

    // Backpressure on C.
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 4'b0100, 1'b0, 8'h00, 8'h00, 8'h3C, 8'h00);
    applyStimulus(4'b0100, 4'b0100, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h00);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 8'h3C, 8'h00);

    // Burst cap with B and C both requesting and no last flags.
    for (int i = 0; i < 12; i++) applyStimulus(4'b0110, 4'b0000, 1'b1, 8'h00, 8'(8'h10 + i), 8'(8'h20 + i), 8'h00);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);

    // Abandon by D under backpressure while A waits.
    for (int i = 0; i < 2; i++) applyStimulus(4'b1000, 4'b0000, 1'b0, 8'hAA, 8'h00, 8'h00, 8'hDD);
    applyStimulus(4'b0001, 4'b0000, 1'b0, 8'hAA, 8'h00, 8'h00, 8'hDD);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0001, 4'b0001, 1'b1, 8'hAA, 8'h00, 8'h00, 8'hDD);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = 4'($urandom);
      l = 4'($urandom) & 4'($urandom);
      applyStimulus(r, l, ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                    8'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 3; i++) applyStimulus(4'b0000, 4'b0000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    #1;
    checkOutput("beats_outstanding", 32'(beat_q.size()), 32'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
